microwave_timer: RTL and testbench

- Cook-timer controller for a microwave oven.
- A start request loads a 4-bit cook time. The block holds the power/magnetron enable `p` high while it counts the time down, one unit per tick. At expiry it drops `p`.
- It sits between the front-panel inputs (start switch, time selector) and the power stage.
- It has a single clock domain. Count progress is gated by a tick-enable input.

---
 rtl/microwave_timer.sv | 128 ++++++++++++
 tb/tb_microwave_timer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/microwave_timer.sv
// -----------------------------------------------------------------------------
// microwave_timer
//
// Cook-timer controller for a microwave oven. A start request latches a cook
// time and holds the power enable high while that time counts down, one unit
// per tick strobe. At expiry power drops and the block waits for the start
// switch to be released before it can be armed again.
//
// Ports
//   clk   in   1       system clock, rising edge
//   tick  in   1       count enable / time-unit strobe (ignored outside COOK)
//   r     in   1       run/start request, level sensitive
//   tin   in   TIME_W  cook time in ticks, 0 = no cooking
//   p     out  1       power enable, registered
//   rst   in   1       asynchronous active-low reset
//
// Build option
//   MWA_PAUSE_EN  when defined, releasing r during COOK pauses the count
//                 instead of aborting it; raising r again resumes it.
//
// States
//   IDLE  | waiting for r=1 with a non-zero cook time
//   COOK  | power on, counting down on tick
//   DONE  | time expired, power off, waiting for r=0
//   PAUSE | (MWA_PAUSE_EN only) power off, count held, waiting for r=1
// -----------------------------------------------------------------------------
module microwave_timer #(
    parameter int TIME_W = 4
) (
    input  logic              clk,
    input  logic              tick,
    input  logic              r,
    input  logic [TIME_W-1:0] tin,
    output logic              p,
    input  logic              rst
);

`ifdef MWA_PAUSE_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COOK  = 2'd1,
        DONE  = 2'd2,
        PAUSE = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COOK  = 2'd1,
        DONE  = 2'd2
    } state_t;
`endif

    state_t            state;
    logic [TIME_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            p     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (r && (tin != '0)) begin
                        state <= COOK;
                        cnt   <= tin;
                        p     <= 1'b1;
                    end else begin
                        cnt   <= '0;
                        p     <= 1'b0;
                    end
                end

                COOK: begin
                    if (!r) begin
`ifdef MWA_PAUSE_EN
                        // count is kept so the cook can resume where it stopped
                        state <= PAUSE;
                        p     <= 1'b0;
`else
                        state <= IDLE;
                        cnt   <= '0;
                        p     <= 1'b0;
`endif
                    end else if (tick) begin
                        // cnt<=1 rather than ==1 so a corrupted zero count can
                        // never wrap around and extend cooking
                        if (cnt <= TIME_W'(1)) begin
                            state <= DONE;
                            cnt   <= '0;
                            p     <= 1'b0;
                        end else begin
                            cnt   <= cnt - TIME_W'(1);
                            p     <= 1'b1;
                        end
                    end else begin
                        p     <= 1'b1;
                    end
                end

                DONE: begin
                    p <= 1'b0;
                    if (!r) begin
                        state <= IDLE;
                    end
                end

`ifdef MWA_PAUSE_EN
                PAUSE: begin
                    if (r) begin
                        state <= COOK;
                        p     <= 1'b1;
                    end else begin
                        p     <= 1'b0;
                    end
                end
`endif

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    p     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_microwave_timer.sv
module tb_microwave_timer;

    localparam int TIME_W = 4;

    logic              clk;
    logic              tick;
    logic              r;
    logic [TIME_W-1:0] tin;
    logic              p;
    logic              rst;

    int errors = 0;
    int checks = 0;

    logic exp_q[$];

    microwave_timer #(.TIME_W(TIME_W)) dut (
        .clk  (clk),
        .tick (tick),
        .r    (r),
        .tin  (tin),
        .p    (p),
        .rst  (rst)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: p=%0b expected %0b", tag, obs, expv);
        end
    endtask

    // Drive inputs on the falling edge, queue the p value expected after the
    // next rising edge, then compare just after that edge.
    task automatic step(input logic rst_v, input logic r_v, input logic [TIME_W-1:0] tin_v,
                        input logic tick_v, input logic expv, input string tag);
        logic e;
        @(negedge clk);
        rst  = rst_v;
        r    = r_v;
        tin  = tin_v;
        tick = tick_v;
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(tag, p, e);
    endtask

    initial begin
        rst  = 1'b0;
        r    = 1'b1;
        tin  = 4'd4;
        tick = 1'b1;

        // reset held with a valid start request present
        #1 check("reset_t0", p, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'd4, 1'b1, 1'b0, "reset_hold");

        // release reset: first sampled edge starts a 4-cycle cook
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'd4, 1'b1, 1'b1, "basic_cook_on");
        step(1'b1, 1'b1, 4'd4, 1'b1, 1'b0, "basic_cook_expire");
        // r still high: DONE must not re-trigger
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'd4, 1'b1, 1'b0, "done_no_retrigger");

        // re-arm with tin=2
        step(1'b1, 1'b0, 4'd2, 1'b1, 1'b0, "rearm_release");
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 4'd2, 1'b1, 1'b1, "rearm_on");
        step(1'b1, 1'b1, 4'd2, 1'b1, 1'b0, "rearm_expire");
        step(1'b1, 1'b0, 4'd2, 1'b1, 1'b0, "rearm_idle");

        // zero cook time never powers up
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 4'd0, 1'b1, 1'b0, "zero_time");
        step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, "zero_time_release");

        // abort/pause after two ticks have been consumed (cnt 6 -> 4)
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'd6, 1'b1, 1'b1, "abort_cook_on");
        step(1'b1, 1'b0, 4'd6, 1'b1, 1'b0, "abort_drop_r");
`ifdef MWA_PAUSE_EN
        step(1'b1, 1'b0, 4'd6, 1'b1, 1'b0, "pause_hold");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'd6, 1'b1, 1'b1, "pause_resume_on");
        step(1'b1, 1'b1, 4'd6, 1'b1, 1'b0, "pause_resume_expire");
`else
        step(1'b1, 1'b0, 4'd6, 1'b1, 1'b0, "abort_idle");
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 4'd6, 1'b1, 1'b1, "abort_restart_full");
        step(1'b1, 1'b1, 4'd6, 1'b1, 1'b0, "abort_restart_expire");
`endif
        step(1'b1, 1'b0, 4'd6, 1'b1, 1'b0, "abort_release");

        // tick gating: tick every 4th edge, tin=3 gives 12 cycles; tin bumped mid-cook
        step(1'b1, 1'b1, 4'd3, 1'b0, 1'b1, "gate_load");
        for (int i = 1; i <= 12; i++)
            step(1'b1, 1'b1, (i >= 5) ? 4'd9 : 4'd3, (i % 4) == 0, i < 12, "gate_count");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'd9, 1'b1, 1'b0, "gate_done");
        step(1'b1, 1'b0, 4'd9, 1'b1, 1'b0, "gate_release");

        // maximum cook time
        for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 4'hF, 1'b1, 1'b1, "max_time_on");
        step(1'b1, 1'b1, 4'hF, 1'b1, 1'b0, "max_time_expire");
        step(1'b1, 1'b0, 4'hF, 1'b1, 1'b0, "max_time_release");

        // asynchronous reset in the middle of a cook
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'd8, 1'b1, 1'b1, "async_cook_on");
        #5 rst = 1'b0;
        #1 check("async_reset_immediate", p, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 4'd8, 1'b1, 1'b0, "async_reset_hold");
        // release with r low: stays idle
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 4'd8, 1'b1, 1'b0, "after_reset_idle");
        step(1'b1, 1'b1, 4'd1, 1'b1, 1'b1, "single_tick_on");
        step(1'b1, 1'b1, 4'd1, 1'b1, 1'b0, "single_tick_expire");

        check("scoreboard_empty", exp_q.size() == 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
